// File: rtl/fxp_pkg.sv
// Purpose: shared fixed-point helpers (widths, saturation limits) and accumulator FSM state type.
// Latency: none, package only.
// Backpressure: n/a.
package fxp_pkg;

    localparam int SAT_MAX_W = 128;

    typedef enum logic {
        ACC_IDLE,
        ACC_ACCUM
    } acc_state_t;

    function automatic int acc_width(input int data_w, input int coef_w, input int guard_w);
        return data_w + coef_w + guard_w;
    endfunction

    function automatic int cnt_width(input int max_frame);
        return $clog2(max_frame + 1);
    endfunction

    // Largest representable value of a w-bit word, returned LSB-aligned in a wide container.
    function automatic logic [SAT_MAX_W-1:0] sat_max(input int w, input bit is_signed);
        if (is_signed)
            return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
        else
            return (SAT_MAX_W'(1) << w) - SAT_MAX_W'(1);
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_min(input int w, input bit is_signed);
        if (is_signed)
            return SAT_MAX_W'(1) << (w - 1);
        else
            return '0;
    endfunction

endpackage

// File: rtl/mac_product_pipe.sv
// Purpose: registers a sample/coef pair, multiplies, and extends the product to accumulator width.
// Latency: 2 enabled edges from input to prod_vld/prod_dat.
// Backpressure: none; ena=0 freezes both stages.
module mac_product_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter bit IS_SIGNED  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [COEF_WIDTH-1:0] coef,
    output logic                  prod_vld,
    output logic                  prod_last,
    output logic [ACC_WIDTH-1:0]  prod_dat
);

    localparam int PW = DATA_WIDTH + COEF_WIDTH;

    logic                  s1_vld;
    logic                  s1_last;
    logic [DATA_WIDTH-1:0] s1_din;
    logic [COEF_WIDTH-1:0] s1_coef;
    logic [PW-1:0]         prod_full;
    logic [ACC_WIDTH-1:0]  prod_ext;

    // A PW-bit product of PW-bit extended operands is exact for both signednesses.
    generate
        if (IS_SIGNED) begin : g_signed
            assign prod_full = PW'($signed(s1_din)) * PW'($signed(s1_coef));
            assign prod_ext  = ACC_WIDTH'($signed(prod_full));
        end else begin : g_unsigned
            assign prod_full = PW'(s1_din) * PW'(s1_coef);
            assign prod_ext  = ACC_WIDTH'(prod_full);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            s1_din    <= '0;
            s1_coef   <= '0;
            prod_vld  <= 1'b0;
            prod_last <= 1'b0;
            prod_dat  <= '0;
        end else if (ena) begin
            s1_vld    <= in_valid;
            s1_last   <= in_last & in_valid;
            s1_din    <= din;
            s1_coef   <= coef;
            prod_vld  <= s1_vld;
            prod_last <= s1_last;
            prod_dat  <= prod_ext;
        end
    end

endmodule

// File: rtl/mac_frame_accumulator.sv
// Purpose: framed multiply-accumulate, one sum/count/flags result per frame; MAC_ACC_SATURATE_EN clamps on overflow.
// Latency: 3 enabled edges from the last sample to out_valid.
// Backpressure: none; ena=0 freezes every register, outputs hold.
module mac_frame_accumulator
    import fxp_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int COEF_WIDTH = 16,
    parameter  int GUARD_BITS = 8,
    parameter  int MAX_FRAME  = 256,
    parameter  bit IS_SIGNED  = 1'b1,
    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, COEF_WIDTH, GUARD_BITS),
    localparam int CNT_WIDTH  = cnt_width(MAX_FRAME)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [COEF_WIDTH-1:0] coef,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_ovf,
    output logic                  out_trunc
);

    localparam int MSB = ACC_WIDTH - 1;

`ifdef MAC_ACC_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH, IS_SIGNED));
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH, IS_SIGNED));
`endif

    logic                 prod_vld;
    logic                 prod_last;
    logic [ACC_WIDTH-1:0] prod_dat;

    acc_state_t           state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 ovf_sticky;

    logic [ACC_WIDTH-1:0] base_acc;
    logic [CNT_WIDTH-1:0] base_cnt;
    logic                 base_ovf;
    logic [ACC_WIDTH:0]   sum_ext;
    logic [ACC_WIDTH-1:0] sum;
    logic                 ovf_now;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 frame_end;

    mac_product_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .IS_SIGNED  (IS_SIGNED)
    ) u_product_pipe (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .din       (din),
        .coef      (coef),
        .prod_vld  (prod_vld),
        .prod_last (prod_last),
        .prod_dat  (prod_dat)
    );

    // Starting from zero in IDLE makes the first product a plain load that can never overflow.
    always_comb begin
        base_acc = (state == ACC_ACCUM) ? acc : '0;
        base_cnt = (state == ACC_ACCUM) ? cnt : '0;
        base_ovf = (state == ACC_ACCUM) ? ovf_sticky : 1'b0;
        sum_ext  = {1'b0, base_acc} + {1'b0, prod_dat};
        sum      = sum_ext[ACC_WIDTH-1:0];
        if (IS_SIGNED)
            ovf_now = (base_acc[MSB] == prod_dat[MSB]) && (sum[MSB] != prod_dat[MSB]);
        else
            ovf_now = sum_ext[ACC_WIDTH];
`ifdef MAC_ACC_SATURATE_EN
        if (ovf_now)
            acc_next = (IS_SIGNED && prod_dat[MSB]) ? ACC_MIN : ACC_MAX;
        else
            acc_next = sum;
`else
        acc_next = sum;
`endif
        cnt_next  = base_cnt + CNT_WIDTH'(1);
        frame_end = prod_vld && (prod_last || (cnt_next == CNT_WIDTH'(MAX_FRAME)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACC_IDLE;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
            out_trunc  <= 1'b0;
        end else if (ena) begin
            out_valid <= frame_end;
            if (frame_end) begin
                out_data   <= acc_next;
                out_count  <= cnt_next;
                out_ovf    <= base_ovf | ovf_now;
                out_trunc  <= ~prod_last;
                state      <= ACC_IDLE;
                acc        <= '0;
                cnt        <= '0;
                ovf_sticky <= 1'b0;
            end else if (prod_vld) begin
                state      <= ACC_ACCUM;
                acc        <= acc_next;
                cnt        <= cnt_next;
                ovf_sticky <= base_ovf | ovf_now;
            end
        end
    end

endmodule

// File: tb/tb_mac_frame_accumulator.sv
// Bench: default instance plus a GUARD_BITS=0 / MAX_FRAME=4 instance on a shared input bus,
// checked every cycle against an arithmetic frame-sum reference.
module tb_mac_frame_accumulator;

    typedef struct {
        longint data;
        int     cnt;
        bit     ovf;
        bit     trunc;
        longint edge_n;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        in_valid;
    logic        in_last;
    logic [15:0] din;
    logic [15:0] coef;

    logic        a_valid, a_ovf, a_trunc;
    logic [39:0] a_data;
    logic [8:0]  a_count;
    logic        b_valid, b_ovf, b_trunc;
    logic [31:0] b_data;
    logic [2:0]  b_count;

    int     n_cmp = 0;
    int     n_fail = 0;
    longint eidx = 0;
    exp_t   qa[$];
    exp_t   qb[$];
    longint m_sum[2];
    int     m_cnt[2];
    bit     m_ovf[2];
    logic [39:0] a_seen;
    logic [31:0] b_seen;
    bit     b_ovf_seen;
    int     b_trunc_seen;
    int     a_pops;

    mac_frame_accumulator dut_a (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_last(in_last),
        .din(din), .coef(coef), .out_valid(a_valid), .out_data(a_data),
        .out_count(a_count), .out_ovf(a_ovf), .out_trunc(a_trunc)
    );

    mac_frame_accumulator #(.GUARD_BITS(0), .MAX_FRAME(4)) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_last(in_last),
        .din(din), .coef(coef), .out_valid(b_valid), .out_data(b_data),
        .out_count(b_count), .out_ovf(b_ovf), .out_trunc(b_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer frame sum, wrapped or clamped to the accumulator range after each add.
    task automatic model_sample(input int i, input logic [15:0] d, input logic [15:0] c,
                                input bit last, output bit push, output exp_t e);
        longint prod, s, hi, lo;
        int w, mf;
        w    = (i == 0) ? 40 : 32;
        mf   = (i == 0) ? 256 : 4;
        prod = longint'($signed(d)) * longint'($signed(c));
        s    = ((m_cnt[i] == 0) ? 64'sd0 : m_sum[i]) + prod;
        hi   = (longint'(1) <<< (w - 1)) - 1;
        lo   = -hi - 1;
        if (s > hi || s < lo) begin
            m_ovf[i] = 1'b1;
`ifdef MAC_ACC_SATURATE_EN
            s = (s > hi) ? hi : lo;
`else
            s = (s <<< (64 - w)) >>> (64 - w);
`endif
        end
        m_sum[i] = s;
        m_cnt[i]++;
        push     = last || (m_cnt[i] == mf);
        e.data   = s;
        e.cnt    = m_cnt[i];
        e.ovf    = m_ovf[i];
        e.trunc  = !last;
        e.edge_n = eidx + 3;
        if (push) begin
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
            m_sum[i] = 0;
        end
    endtask

    task automatic check_outputs();
        bit due;
        longint t;
        due = (qa.size() > 0) && (qa[0].edge_n <= eidx);
        cmp("a_valid", 64'(a_valid), 64'(due));
        if (due) begin
            t = qa[0].data;
            cmp("a_data", 64'(a_data), 64'(t[39:0]));
            cmp("a_count", 64'(a_count), 64'(qa[0].cnt));
            cmp("a_ovf", 64'(a_ovf), 64'(qa[0].ovf));
            cmp("a_trunc", 64'(a_trunc), 64'(qa[0].trunc));
            if (ena) begin
                a_seen = a_data;
                a_pops++;
                void'(qa.pop_front());
            end
        end
        due = (qb.size() > 0) && (qb[0].edge_n <= eidx);
        cmp("b_valid", 64'(b_valid), 64'(due));
        if (due) begin
            t = qb[0].data;
            cmp("b_data", 64'(b_data), 64'(t[31:0]));
            cmp("b_count", 64'(b_count), 64'(qb[0].cnt));
            cmp("b_ovf", 64'(b_ovf), 64'(qb[0].ovf));
            cmp("b_trunc", 64'(b_trunc), 64'(qb[0].trunc));
            if (ena) begin
                b_seen     = b_data;
                b_ovf_seen = b_ovf;
                if (b_trunc) b_trunc_seen++;
                void'(qb.pop_front());
            end
        end
    endtask

    task automatic step(input bit e, input bit v, input bit l, input logic [15:0] d, input logic [15:0] c);
        bit pa, pb;
        exp_t ea, eb;
        ena = e; in_valid = v; in_last = l; din = d; coef = c;
        if (e && v) begin
            model_sample(0, d, c, l, pa, ea);
            if (pa) qa.push_back(ea);
            model_sample(1, d, c, l, pb, eb);
            if (pb) qb.push_back(eb);
        end
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (e) eidx++;
        #1;
    endtask

    task automatic drain();
        repeat (6) step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        cmp("a_queue_empty", 64'(qa.size()), 64'd0);
        cmp("b_queue_empty", 64'(qb.size()), 64'd0);
    endtask

    task automatic do_reset(input bit e);
        rst = 1'b1; ena = e; in_valid = 1'b1; in_last = 1'b1;
        din = 16'($urandom); coef = 16'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0; ena = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_ovf[i] = 1'b0; m_sum[i] = 0;
        end
        qa.delete();
        qb.delete();
        cmp("rst_a_valid", 64'(a_valid), 64'd0);
        cmp("rst_a_data", 64'(a_data), 64'd0);
        cmp("rst_a_count", 64'(a_count), 64'd0);
        cmp("rst_a_ovf", 64'(a_ovf), 64'd0);
        cmp("rst_a_trunc", 64'(a_trunc), 64'd0);
        cmp("rst_b_valid", 64'(b_valid), 64'd0);
        cmp("rst_b_data", 64'(b_data), 64'd0);
        cmp("rst_b_count", 64'(b_count), 64'd0);
        cmp("rst_b_ovf", 64'(b_ovf), 64'd0);
        cmp("rst_b_trunc", 64'(b_trunc), 64'd0);
    endtask

    initial begin
        int pops_before;
        rst = 1'b1; ena = 1'b0; in_valid = 1'b0; in_last = 1'b0; din = '0; coef = '0;
        a_pops = 0; b_trunc_seen = 0; b_ovf_seen = 1'b0;
        do_reset(1'b0);

        // 1,2,3,4 x 10 -> 100
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b1, k == 4, 16'(k), 16'd10);
        drain();
        cmp("sum_100", 64'(a_seen), 64'd100);

        // signed extremes and a negative result, back-to-back single-sample frames
        step(1'b1, 1'b1, 1'b1, 16'h8000, 16'h8000);
        step(1'b1, 1'b1, 1'b1, 16'hFFFE, 16'd3);
        drain();
        cmp("neg6_sign_ext", 64'(a_seen), 64'h00_0000_FF_FFFF_FFFA);

        // three (-32768)^2 products overflow the 32-bit accumulator
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, k == 2, 16'h8000, 16'h8000);
        drain();
        cmp("a_no_ovf_sum", 64'(a_seen), 64'd3221225472);
        cmp("b_ovf_flag", 64'(b_ovf_seen), 64'd1);
`ifdef MAC_ACC_SATURATE_EN
        cmp("b_sat_sum", 64'(b_seen), 64'h7FFF_FFFF);
`else
        cmp("b_wrap_sum", 64'(b_seen), 64'hC000_0000);
`endif

        // back-to-back frames with no input bubble
        step(1'b1, 1'b1, 1'b1, 16'd5, 16'd2);
        step(1'b1, 1'b1, 1'b0, 16'd3, 16'd1);
        step(1'b1, 1'b1, 1'b1, 16'd3, 16'd1);
        drain();
        cmp("b2b_second", 64'(a_seen), 64'd6);

        // ena low mid-frame and while the result is presented
        pops_before = a_pops;
        step(1'b1, 1'b1, 1'b0, 16'd1, 16'd1);
        step(1'b1, 1'b1, 1'b0, 16'd2, 16'd1);
        repeat (5) step(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
        step(1'b1, 1'b1, 1'b1, 16'd3, 16'd1);
        step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        drain();
        cmp("ena_sum", 64'(a_seen), 64'd6);
        cmp("ena_seen_once", 64'(a_pops - pops_before), 64'd1);

        // reset drops a partial frame
        step(1'b1, 1'b1, 1'b0, 16'd9, 16'd9);
        step(1'b1, 1'b1, 1'b0, 16'd9, 16'd9);
        do_reset(1'b0);
        step(1'b1, 1'b1, 1'b1, 16'd7, 16'd1);
        drain();
        cmp("post_rst_sum", 64'(a_seen), 64'd7);

        // MAX_FRAME=4 truncation, fifth sample opens a new frame
        b_trunc_seen = 0;
        repeat (5) step(1'b1, 1'b1, 1'b0, 16'd1, 16'd1);
        step(1'b1, 1'b1, 1'b1, 16'd1, 16'd1);
        drain();
        cmp("b_trunc_once", 64'(b_trunc_seen), 64'd1);
        cmp("b_tail_frame", 64'(b_seen), 64'd2);
        cmp("a_untrunc_sum", 64'(a_seen), 64'd6);

        // randomized traffic
        for (int n = 0; n < 800; n++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
                 16'($urandom), 16'($urandom));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
